mem_trans_gen: RTL and testbench
================================

Name: mem_trans_gen

Overview:
- Test-traffic transaction generator for the memory checker.
- Sits directly upstream of the AMM transaction/burst stage. It turns the latched test CSR configuration into a stream of trans_struct_t packets: packet type, word address, burst low bits, start/end byte offsets.
- Implements all addr_mode_t address patterns and all test_mode_t read/write sequencing.
- Output handshake is valid/ready.

Parameters:
ADDR_W, settings_pkg::ADDR_W (32), word-address width of trans_struct_t.word_addr
ADDR_B_W, settings_pkg::ADDR_B_W (4), byte-offset-within-word width
CNT_W, 32, transaction counter width

Ports:
clk_i  input  1  system clock
rst_n_i  input  1  asynchronous active-low reset
start_i  input  1  one-cycle start pulse; ignored unless FSM in IDLE
test_mode_i  input  2  test_mode_t
addr_mode_i  input  3  addr_mode_t
fix_addr_i  input  ADDR_W  base/fixed word address
rnd_seed_i  input  32  LFSR seed
trans_amount_i  input  CNT_W  number of addresses to generate
bytes_count_i  input  AMM_BURST_W+ADDR_B_W  bytes per transaction, >=1
start_offset_i  input  ADDR_B_W  first-byte offset in first word
trans_o  output  $bits(trans_struct_t)  packet
trans_valid_o  output  1  packet valid
trans_ready_i  input  1  downstream accepts packet
busy_o  output  1  generation in progress
done_o  output  1  one-cycle pulse when run finishes

Behaviour:
- Reset values: trans_valid_o=0, trans_o=0, busy_o=0, done_o=0. FSM=IDLE, counters=0, LFSR=1, walk index=0.
- States: IDLE, GEN_WR, GEN_RD, DONE.
- All inputs except trans_ready_i are sampled only on the start_i cycle in IDLE. Later input changes do not affect the run.
- IDLE, start_i=1, next state by latched config:
  - trans_amount_i==0 or test_mode_i==2'b00 -> DONE.
  - test_mode_i==READ_ONLY -> GEN_RD.
  - Otherwise -> GEN_WR.
  - LFSR loads rnd_seed_i; a seed of 0 is replaced by 1.
- Latency: start_i in cycle N -> trans_valid_o=1 in cycle N+1, carrying the first address.
- Handshake:
  - Transfer occurs when trans_valid_o && trans_ready_i.
  - trans_o is held stable while valid && !ready.
  - valid never drops without a transfer, except on reset.
- Packet fields:
  - pkt_type = 1 in GEN_WR, 0 in GEN_RD.
  - start_offset = latched start_offset_i.
  - end_offset = (start_offset + bytes_count - 1)[ADDR_B_W-1:0].
  - low_burst_bits = (start_offset + bytes_count - 1)[ADDR_B_W:0], computed at full width before truncation.
- Address by mode; n = address index, 0..trans_amount-1:
  - FIX_ADDR: fix_addr.
  - INC_ADDR: fix_addr + n, modulo 2^ADDR_W (wraps silently).
  - RUN_1_ADDR: 1 << (n mod ADDR_W).
  - RUN_0_ADDR: ~(1 << (n mod ADDR_W)).
  - RND_ADDR: lfsr[ADDR_W-1:0]. The LFSR is a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1 (mask 32'h80200003), shifting right. It advances once per address advance. The first address is the seed value.
  - Reserved codes 3'b101..3'b111: behave as FIX_ADDR.
- Sequencing:
  - WRITE_ONLY: GEN_WR only. Address advances on each transfer.
  - READ_ONLY: GEN_RD only. Address advances on each transfer.
  - WRITE_AND_CHECK: each address emitted as a write (GEN_WR), then a read of the identical packet except pkt_type (GEN_RD). The address advances only after the read transfer.
- Transfers are back-to-back with no bubble when ready is held high: one transfer per cycle.
- Completion:
  - After the transfer of the last address (its read in WRITE_AND_CHECK), next state is DONE and valid drops.
  - DONE lasts one cycle, asserts done_o, then returns to IDLE.
- busy_o = 1 in GEN_WR/GEN_RD/DONE, 0 in IDLE.
- start_i while busy is ignored, with no restart.
- Asynchronous reset mid-run: immediate return to reset values. No done_o pulse, and the partial run is discarded.

Test Plan:
- FIX/WRITE_ONLY: fix_addr=0x100, amount=3, bytes=16, offset=0, ready=1 -> 3 writes to 0x100, end_offset=0xF, low_burst_bits=0x0F; done_o 1 cycle after the 3rd transfer; first valid at N+1.
- INC wrap/READ_ONLY: fix_addr=0xFFFFFFFE, amount=4 -> reads at 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- RUN_1 and RUN_0: amount=34 -> RUN_1 gives 0x1 … 0x80000000, then 0x1, 0x2; RUN_0 gives the bitwise complements.
- WRITE_AND_CHECK with random ready (50%): amount=5 -> exactly 10 transfers in W,R pairs with matching addresses; trans_o stable during stalls; offset=15, bytes=2 -> end_offset=0, low_burst_bits=0x10.
- RND with seed=0: first address 0x1, following addresses match a reference Galois LFSR (mask 0x80200003); amount=0 -> no valid, done_o at N+1.
- rst_n_i asserted mid-run after 2 of 8 transfers: valid/busy drop immediately, no done_o; a new start restarts from address index 0.

Source files
------------

// File: rtl/mem_trans_gen.sv
// Test-traffic generator for the memory checker: expands the latched
// test configuration into a valid/ready stream of trans_struct_t packets.
package settings_pkg;
  localparam int ADDR_W      = 32;
  localparam int ADDR_B_W    = 4;
  localparam int AMM_BURST_W = 11;

  typedef enum logic [1:0] {
    TEST_NONE       = 2'b00,
    WRITE_ONLY      = 2'b01,
    READ_ONLY       = 2'b10,
    WRITE_AND_CHECK = 2'b11
  } test_mode_t;

  typedef enum logic [2:0] {
    FIX_ADDR   = 3'b000,
    INC_ADDR   = 3'b001,
    RUN_1_ADDR = 3'b010,
    RUN_0_ADDR = 3'b011,
    RND_ADDR   = 3'b100
  } addr_mode_t;

  typedef struct packed {
    logic                pkt_type;
    logic [ADDR_W-1:0]   word_addr;
    logic [ADDR_B_W:0]   low_burst_bits;
    logic [ADDR_B_W-1:0] start_offset;
    logic [ADDR_B_W-1:0] end_offset;
  } trans_struct_t;
endpackage

module mem_trans_gen #(
  parameter int ADDR_W   = settings_pkg::ADDR_W,
  parameter int ADDR_B_W = settings_pkg::ADDR_B_W,
  parameter int CNT_W    = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [1:0]            test_mode_i,
  input  logic [2:0]            addr_mode_i,
  input  logic [ADDR_W-1:0]     fix_addr_i,
  input  logic [31:0]           rnd_seed_i,
  input  logic [CNT_W-1:0]      trans_amount_i,
  input  logic [settings_pkg::AMM_BURST_W+ADDR_B_W-1:0] bytes_count_i,
  input  logic [ADDR_B_W-1:0]   start_offset_i,
  output logic [ADDR_W+3*ADDR_B_W+1:0] trans_o,
  output logic                  trans_valid_o,
  input  logic                  trans_ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int BC_W   = settings_pkg::AMM_BURST_W + ADDR_B_W;
  localparam int SUM_W  = BC_W + 1;
  localparam int WALK_W = $clog2(ADDR_W);
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GEN_WR,
    S_GEN_RD,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [1:0]          r_test;
  logic [2:0]          r_amode;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W-1:0]   r_inc;
  logic [31:0]         r_lfsr;
  logic [CNT_W-1:0]    r_left;
  logic [WALK_W-1:0]   r_walk;
  logic [ADDR_B_W-1:0] r_soff;
  logic [ADDR_B_W:0]   r_lbb;

  logic [SUM_W-1:0]    w_sum;
  logic [31:0]         w_seed;
  logic [31:0]         w_lfsr_nxt;
  logic [ADDR_W-1:0]   w_one_hot;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_start;
  logic                w_empty;
  logic                w_valid;
  logic                w_xfer;
  logic                w_wac;
  logic                w_adv;
  logic                w_last;
  logic                w_unused;

  // Last byte position; bit ADDR_B_W is the carry into the next word.
  assign w_sum = SUM_W'(start_offset_i)
               + SUM_W'(bytes_count_i)
               - SUM_W'(1);
  assign w_unused = ^w_sum[SUM_W-1:ADDR_B_W+1];

  assign w_seed = (rnd_seed_i == '0) ? 32'd1 : rnd_seed_i;
  assign w_lfsr_nxt = {1'b0, r_lfsr[31:1]}
                    ^ (r_lfsr[0] ? LFSR_MASK : '0);

  assign w_start = start_i && (r_state == S_IDLE);
  assign w_empty = (trans_amount_i == '0)
                || (test_mode_i == settings_pkg::TEST_NONE);
  assign w_valid = (r_state == S_GEN_WR) || (r_state == S_GEN_RD);
  assign w_xfer  = w_valid && trans_ready_i;
  assign w_wac   = (r_test == settings_pkg::WRITE_AND_CHECK);
  assign w_last  = (r_left == CNT_W'(1));

  // In write-and-check the address is held until its read goes out.
  assign w_adv = w_xfer && !((r_state == S_GEN_WR) && w_wac);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if (w_empty) begin
            w_next = S_DONE;
          end else if (test_mode_i == settings_pkg::READ_ONLY) begin
            w_next = S_GEN_RD;
          end else begin
            w_next = S_GEN_WR;
          end
        end
      end
      S_GEN_WR: begin
        if (w_xfer) begin
          if (w_wac) begin
            w_next = S_GEN_RD;
          end else if (w_last) begin
            w_next = S_DONE;
          end
        end
      end
      S_GEN_RD: begin
        if (w_xfer) begin
          if (w_last) begin
            w_next = S_DONE;
          end else if (w_wac) begin
            w_next = S_GEN_WR;
          end
        end
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_test  <= '0;
      r_amode <= '0;
      r_base  <= '0;
      r_inc   <= '0;
      r_lfsr  <= 32'd1;
      r_left  <= '0;
      r_walk  <= '0;
      r_soff  <= '0;
      r_lbb   <= '0;
    end else if (w_start) begin
      r_test  <= test_mode_i;
      r_amode <= addr_mode_i;
      r_base  <= fix_addr_i;
      r_inc   <= fix_addr_i;
      r_lfsr  <= w_seed;
      r_left  <= trans_amount_i;
      r_walk  <= '0;
      r_soff  <= start_offset_i;
      r_lbb   <= w_sum[ADDR_B_W:0];
    end else if (w_adv) begin
      r_left <= r_left - CNT_W'(1);
      r_inc  <= r_inc + ADDR_W'(1);
      r_lfsr <= w_lfsr_nxt;
      if (r_walk == WALK_W'(ADDR_W - 1)) begin
        r_walk <= '0;
      end else begin
        r_walk <= r_walk + WALK_W'(1);
      end
    end
  end

  // Reserved mode codes fall through to the fixed address.
  always_comb begin
    w_one_hot = ADDR_W'(1) << r_walk;
    unique case (1'b1)
      (r_amode == settings_pkg::INC_ADDR):   w_addr = r_inc;
      (r_amode == settings_pkg::RUN_1_ADDR): w_addr = w_one_hot;
      (r_amode == settings_pkg::RUN_0_ADDR): w_addr = ~w_one_hot;
      (r_amode == settings_pkg::RND_ADDR):   w_addr = r_lfsr[ADDR_W-1:0];
      default:                               w_addr = r_base;
    endcase
  end

  always_comb begin
    trans_valid_o = 1'b0;
    trans_o       = '0;
    busy_o        = (r_state != S_IDLE);
    done_o        = (r_state == S_DONE);
    if (w_valid) begin
      trans_valid_o = 1'b1;
      trans_o = {(r_state == S_GEN_WR), w_addr, r_lbb,
                 r_soff, r_lbb[ADDR_B_W-1:0]};
    end
  end

endmodule

// File: tb/tb_mem_trans_gen.sv
// Bench for mem_trans_gen: packet-list model plus per-cycle compare,
// with literal checks on selected packets of each directed run.
module tb_mem_trans_gen;
  import settings_pkg::*;

  logic        clk_i;
  logic        rst_n_i;
  logic        start_i;
  logic [1:0]  test_mode_i;
  logic [2:0]  addr_mode_i;
  logic [31:0] fix_addr_i;
  logic [31:0] rnd_seed_i;
  logic [31:0] trans_amount_i;
  logic [14:0] bytes_count_i;
  logic [3:0]  start_offset_i;
  logic [45:0] trans_o;
  logic        trans_valid_o;
  logic        trans_ready_i;
  logic        busy_o;
  logic        done_o;

  mem_trans_gen dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .start_i        (start_i),
    .test_mode_i    (test_mode_i),
    .addr_mode_i    (addr_mode_i),
    .fix_addr_i     (fix_addr_i),
    .rnd_seed_i     (rnd_seed_i),
    .trans_amount_i (trans_amount_i),
    .bytes_count_i  (bytes_count_i),
    .start_offset_i (start_offset_i),
    .trans_o        (trans_o),
    .trans_valid_o  (trans_valid_o),
    .trans_ready_i  (trans_ready_i),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  trans_struct_t exp_q[$];
  trans_struct_t got_q[$];
  bit m_active = 0;
  bit m_done   = 0;
  bit m_nd;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    logic [31:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 32'h8020_0003;
    return y;
  endfunction

  function automatic logic [31:0] model_addr(input logic [2:0] am,
      input logic [31:0] base, input logic [31:0] lf,
      input int unsigned n);
    logic [31:0] oh;
    oh = 32'h1 << (n % 32);
    case (am)
      3'd1:    return base + n;
      3'd2:    return oh;
      3'd3:    return ~oh;
      3'd4:    return lf;
      default: return base;
    endcase
  endfunction

  task automatic build_exp(input logic [1:0] tm, input logic [2:0] am,
      input logic [31:0] base, input logic [31:0] seed,
      input logic [31:0] amt, input logic [14:0] bytes,
      input logic [3:0] off);
    logic [31:0] lf;
    int sum;
    trans_struct_t p;
    lf  = (seed == 0) ? 32'd1 : seed;
    sum = int'(off) + int'(bytes) - 1;
    if (tm == 2'b00) return;
    for (int unsigned n = 0; n < amt; n++) begin
      p.word_addr      = model_addr(am, base, lf, n);
      p.low_burst_bits = sum[4:0];
      p.start_offset   = off;
      p.end_offset     = sum[3:0];
      p.pkt_type       = (tm != 2'b10);
      exp_q.push_back(p);
      if (tm == 2'b11) begin
        p.pkt_type = 1'b0;
        exp_q.push_back(p);
      end
      lf = lfsr_step(lf);
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      exp_q.delete();
      m_active = 0;
      m_done   = 0;
      chk("rst_valid", 64'(trans_valid_o), 64'd0);
      chk("rst_trans", 64'(trans_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
    end else begin
      chk("valid", 64'(trans_valid_o), 64'(m_active));
      chk("busy", 64'(busy_o), 64'(m_active || m_done));
      chk("done", 64'(done_o), 64'(m_done));
      if (m_active && trans_valid_o)
        chk("trans", 64'(trans_o), 64'(exp_q[0]));
      m_nd = 0;
      if (m_active) begin
        if (trans_valid_o && trans_ready_i) begin
          got_q.push_back(trans_struct_t'(trans_o));
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            m_active = 0;
            m_nd = 1;
          end
        end
      end else if (!m_done && start_i) begin
        build_exp(test_mode_i, addr_mode_i, fix_addr_i, rnd_seed_i,
                  trans_amount_i, bytes_count_i, start_offset_i);
        if (exp_q.size() == 0) m_nd = 1;
        else m_active = 1;
      end
      m_done = m_nd;
    end
  end

  task automatic chk_pkt(input string nm, input int idx,
                         input logic [45:0] exp);
    if (idx >= got_q.size()) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: packet %0d missing, have %0d", nm, idx,
               got_q.size());
    end else begin
      chk(nm, 64'(got_q[idx]), 64'(exp));
    end
  endtask

  function automatic logic [45:0] pk(input logic t, input logic [31:0] a,
      input logic [4:0] lbb, input logic [3:0] so, input logic [3:0] eo);
    trans_struct_t p;
    p.pkt_type = t;
    p.word_addr = a;
    p.low_burst_bits = lbb;
    p.start_offset = so;
    p.end_offset = eo;
    return p;
  endfunction

  task automatic scramble();
    test_mode_i    = 2'($urandom);
    addr_mode_i    = 3'($urandom);
    fix_addr_i     = $urandom;
    rnd_seed_i     = $urandom;
    trans_amount_i = $urandom;
    bytes_count_i  = 15'($urandom);
    start_offset_i = 4'($urandom);
  endtask

  task automatic run_cfg(input logic [1:0] tm, input logic [2:0] am,
      input logic [31:0] base, input logic [31:0] seed,
      input logic [31:0] amt, input logic [14:0] bytes,
      input logic [3:0] off, input bit rnd_rdy, input bit dbl,
      output int lat);
    bit seen;
    @(posedge clk_i);
    #1;
    got_q.delete();
    test_mode_i    = tm;
    addr_mode_i    = am;
    fix_addr_i     = base;
    rnd_seed_i     = seed;
    trans_amount_i = amt;
    bytes_count_i  = bytes;
    start_offset_i = off;
    start_i        = 1'b1;
    trans_ready_i  = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    scramble();
    trans_ready_i = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    seen = 0;
    lat  = 0;
    for (int c = 1; c <= 300 && !seen; c++) begin
      @(negedge clk_i);
      if (done_o) begin
        seen = 1;
        lat  = c;
      end else begin
        @(posedge clk_i);
        #1;
        trans_ready_i = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        start_i = dbl && (c == 3);
      end
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    trans_ready_i = 1'b1;
  endtask

  int lat;
  int cnt;

  initial begin
    rst_n_i       = 1'b0;
    start_i       = 1'b0;
    trans_ready_i = 1'b1;
    scramble();
    repeat (3) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;

    chk("lfsr_step1", 64'(lfsr_step(32'd1)), 64'h8020_0003);
    chk("lfsr_step2", 64'(lfsr_step(32'h8020_0003)), 64'hC030_0002);

    run_cfg(2'b01, 3'd0, 32'h100, 0, 3, 15'd16, 4'd0, 0, 0, lat);
    chk("fix_latency", 64'(lat), 64'd4);
    chk("fix_count", 64'(got_q.size()), 64'd3);
    chk_pkt("fix_p0", 0, pk(1, 32'h100, 5'h0F, 4'h0, 4'hF));
    chk_pkt("fix_p2", 2, pk(1, 32'h100, 5'h0F, 4'h0, 4'hF));

    run_cfg(2'b10, 3'd1, 32'hFFFF_FFFE, 0, 4, 15'd16, 4'd0, 0, 0, lat);
    chk("inc_count", 64'(got_q.size()), 64'd4);
    chk_pkt("inc_p0", 0, pk(0, 32'hFFFF_FFFE, 5'h0F, 4'h0, 4'hF));
    chk_pkt("inc_p1", 1, pk(0, 32'hFFFF_FFFF, 5'h0F, 4'h0, 4'hF));
    chk_pkt("inc_p2", 2, pk(0, 32'h0, 5'h0F, 4'h0, 4'hF));
    chk_pkt("inc_p3", 3, pk(0, 32'h1, 5'h0F, 4'h0, 4'hF));

    run_cfg(2'b01, 3'd2, 32'h0, 0, 34, 15'd4, 4'd0, 0, 0, lat);
    chk("run1_count", 64'(got_q.size()), 64'd34);
    chk_pkt("run1_p0", 0, pk(1, 32'h1, 5'h03, 4'h0, 4'h3));
    chk_pkt("run1_p31", 31, pk(1, 32'h8000_0000, 5'h03, 4'h0, 4'h3));
    chk_pkt("run1_p32", 32, pk(1, 32'h1, 5'h03, 4'h0, 4'h3));
    chk_pkt("run1_p33", 33, pk(1, 32'h2, 5'h03, 4'h0, 4'h3));

    run_cfg(2'b10, 3'd3, 32'h0, 0, 34, 15'd4, 4'd0, 1, 0, lat);
    chk("run0_count", 64'(got_q.size()), 64'd34);
    chk_pkt("run0_p0", 0, pk(0, 32'hFFFF_FFFE, 5'h03, 4'h0, 4'h3));
    chk_pkt("run0_p31", 31, pk(0, 32'h7FFF_FFFF, 5'h03, 4'h0, 4'h3));
    chk_pkt("run0_p33", 33, pk(0, 32'hFFFF_FFFD, 5'h03, 4'h0, 4'h3));

    run_cfg(2'b11, 3'd1, 32'h40, 0, 5, 15'd2, 4'd15, 1, 1, lat);
    chk("wac_count", 64'(got_q.size()), 64'd10);
    chk_pkt("wac_p0", 0, pk(1, 32'h40, 5'h10, 4'hF, 4'h0));
    chk_pkt("wac_p1", 1, pk(0, 32'h40, 5'h10, 4'hF, 4'h0));
    chk_pkt("wac_p8", 8, pk(1, 32'h44, 5'h10, 4'hF, 4'h0));
    chk_pkt("wac_p9", 9, pk(0, 32'h44, 5'h10, 4'hF, 4'h0));

    run_cfg(2'b01, 3'd4, 32'h0, 32'h0, 5, 15'd16, 4'd0, 0, 0, lat);
    chk("rnd_count", 64'(got_q.size()), 64'd5);
    chk_pkt("rnd_p0", 0, pk(1, 32'h1, 5'h0F, 4'h0, 4'hF));
    chk_pkt("rnd_p1", 1, pk(1, 32'h8020_0003, 5'h0F, 4'h0, 4'hF));
    chk_pkt("rnd_p2", 2, pk(1, 32'hC030_0002, 5'h0F, 4'h0, 4'hF));

    run_cfg(2'b01, 3'd0, 32'h100, 0, 0, 15'd16, 4'd0, 0, 0, lat);
    chk("amt0_latency", 64'(lat), 64'd1);
    chk("amt0_count", 64'(got_q.size()), 64'd0);

    run_cfg(2'b00, 3'd0, 32'h100, 0, 3, 15'd16, 4'd0, 0, 0, lat);
    chk("none_latency", 64'(lat), 64'd1);

    run_cfg(2'b01, 3'd6, 32'h77, 0, 2, 15'd1, 4'd3, 0, 0, lat);
    chk_pkt("rsv_p1", 1, pk(1, 32'h77, 5'h03, 4'h3, 4'h3));

    @(posedge clk_i);
    #1;
    got_q.delete();
    test_mode_i    = 2'b01;
    addr_mode_i    = 3'd1;
    fix_addr_i     = 32'h1000;
    trans_amount_i = 8;
    bytes_count_i  = 15'd16;
    start_offset_i = 4'd0;
    trans_ready_i  = 1'b1;
    start_i        = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    cnt = 0;
    while (got_q.size() < 2 && cnt < 50) begin
      @(posedge clk_i);
      #1;
      cnt++;
    end
    chk("rst_mid_xfers", 64'(got_q.size()), 64'd2);
    rst_n_i = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(trans_valid_o), 64'd0);
    chk("rst_mid_busy", 64'(busy_o), 64'd0);
    chk("rst_mid_done", 64'(done_o), 64'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    repeat (3) @(posedge clk_i);

    run_cfg(2'b01, 3'd1, 32'h2000, 0, 3, 15'd16, 4'd0, 0, 0, lat);
    chk("restart_count", 64'(got_q.size()), 64'd3);
    chk_pkt("restart_p0", 0, pk(1, 32'h2000, 5'h0F, 4'h0, 4'hF));

    repeat (2) @(posedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
